// File: rtl/huffman_pkg.sv
// huffman_pkg: shared types and constants for the UART-to-decoder byte unstuffing path.
package huffman_pkg;
    localparam int         DEC_WIDTH  = 64;
    localparam logic [7:0] STUFF_BYTE = 8'hFF;

    typedef enum logic {NORMAL, GOT_FF} unstuff_state_t;

    typedef struct packed {
        logic [DEC_WIDTH-1:0] data;
        logic [3:0]           nbytes;
        logic                 last;
        logic [7:0]           marker;
    } DecWord_t;
endpackage

// File: rtl/uart2decoder_if.sv
// uart2decoder_if: byte-stream valid/ready interface between the UART receiver and the unstuffer.
interface UartIF;
    logic [7:0] data;
    logic       valid;
    logic       ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/uart2decoder_unstuff.sv
// ByteUnstuffer: removes 0xFF/0x00 stuffing and emits append/marker strobes for each accepted byte.
// U2D_MARKER_EN selects marker detection on 0xFF followed by a non-zero byte.
module ByteUnstuffer
    import huffman_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] i_byte,
    input  logic       i_take,
    output logic [7:0] o_byte,
    output logic       o_append,
    output logic       o_marker
);
    unstuff_state_t r_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= NORMAL;
        else if (i_take)
            r_state <= (r_state == NORMAL && i_byte == STUFF_BYTE) ? GOT_FF : NORMAL;
    end

    // Strobes are combinational so the packer can register the word on the accepting edge.
    assign o_byte = (r_state == GOT_FF) ? STUFF_BYTE : i_byte;
`ifdef U2D_MARKER_EN
    assign o_append = i_take && (r_state == NORMAL ? i_byte != STUFF_BYTE : i_byte == 8'h00);
    assign o_marker = i_take && r_state == GOT_FF && i_byte != 8'h00;
`else
    assign o_append = i_take && (r_state == GOT_FF || i_byte != STUFF_BYTE);
    assign o_marker = 1'b0;
`endif
endmodule

// File: rtl/uart2decoder.sv
// uart2decoder: unstuffs the UART JPEG byte stream and packs it MSB-first into decoder words.
// U2D_MARKER_EN enables marker flushes with out_last/out_marker.
module uart2decoder
    import huffman_pkg::*;
#(
    parameter int WORD_WIDTH = DEC_WIDTH,
    localparam int BYTES     = WORD_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    UartIF.slave                  in,
    output logic [WORD_WIDTH-1:0] out_data,
    output logic [3:0]            out_nbytes,
    output logic                  out_valid,
    input  logic                  out_ready
`ifdef U2D_MARKER_EN
    ,
    output logic                  out_last,
    output logic [7:0]            out_marker
`endif
);
    DecWord_t              r_out;
    logic                  r_valid;
    logic [WORD_WIDTH-1:0] r_acc;
    logic [3:0]            r_cnt;
    logic [WORD_WIDTH-1:0] w_acc;
    logic [WORD_WIDTH-1:0] w_fill;
    logic [7:0]            w_byte;
    logic                  w_take;
    logic                  w_append;
    logic                  w_marker;

    assign in.ready = !(r_valid && !out_ready);
    assign w_take   = in.valid && in.ready;

    ByteUnstuffer u_unstuff (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_byte  (in.data),
        .i_take  (w_take),
        .o_byte  (w_byte),
        .o_append(w_append),
        .o_marker(w_marker)
    );

    always_comb begin
        w_acc = r_acc;
        w_acc[8*(BYTES-1-int'(r_cnt)) +: 8] = w_byte;
    end

    // Lanes below the filled ones are forced to 0xFF on a marker flush.
    assign w_fill = {WORD_WIDTH{1'b1}} >> (8 * r_cnt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out   <= '0;
            r_valid <= 1'b0;
            r_acc   <= '0;
            r_cnt   <= '0;
        end else begin
            if (out_ready)
                r_valid <= 1'b0;
            if (w_append) begin
                r_acc <= w_acc;
                r_cnt <= (r_cnt == 4'(BYTES - 1)) ? 4'd0 : r_cnt + 4'd1;
                if (r_cnt == 4'(BYTES - 1)) begin
                    r_out   <= '{data: w_acc, nbytes: 4'(BYTES), last: 1'b0, marker: 8'h00};
                    r_valid <= 1'b1;
                end
            end else if (w_marker) begin
                r_out   <= '{data: (r_acc & ~w_fill) | w_fill, nbytes: r_cnt, last: 1'b1, marker: in.data};
                r_valid <= 1'b1;
                r_cnt   <= '0;
            end
        end
    end

    assign out_data   = r_out.data;
    assign out_nbytes = r_out.nbytes;
    assign out_valid  = r_valid;
`ifdef U2D_MARKER_EN
    assign out_last   = r_out.last;
    assign out_marker = r_out.marker;
`else
    logic w_unused;
    assign w_unused = ^{r_out.last, r_out.marker};
`endif
endmodule

// File: tb/tb_uart2decoder.sv
// tb_uart2decoder: directed self-checking bench for uart2decoder (default and U2D_MARKER_EN builds).
module tb_uart2decoder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        out_ready = 1'b1;
    logic [63:0] out_data;
    logic [3:0]  out_nbytes;
    logic        out_valid;
    logic [63:0] held;
    int          n_chk = 0;
    int          n_pass = 0;
`ifdef U2D_MARKER_EN
    logic        out_last;
    logic [7:0]  out_marker;
`endif

    UartIF u_if ();

    uart2decoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in        (u_if),
        .out_data  (out_data),
        .out_nbytes(out_nbytes),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef U2D_MARKER_EN
        ,
        .out_last  (out_last),
        .out_marker(out_marker)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Called at a negedge; offers one byte and returns at the negedge after it was accepted.
    task automatic send(input logic [7:0] b);
        int t = 0;
        u_if.data  = b;
        u_if.valid = 1'b1;
        while (!u_if.ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) check("send_timeout", 64'd0, 64'd1);
        @(negedge clk);
        u_if.valid = 1'b0;
    endtask

    task automatic check_word(input string tag, input logic [63:0] d, input logic [3:0] n);
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_data"}, out_data, d);
        check({tag, "_nbytes"}, 64'(out_nbytes), 64'(n));
    endtask

    initial begin
        u_if.data  = 8'h00;
        u_if.valid = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_data", out_data, 64'd0);
        check("rst_nbytes", 64'(out_nbytes), 64'd0);
        check("rst_ready", 64'(u_if.ready), 64'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // Plain word, out_ready high
        for (int i = 1; i <= 7; i++) send(8'(i));
        check("w1_early_valid", 64'(out_valid), 64'd0);
        send(8'h08);
        check_word("w1", 64'h0102030405060708, 4'd8);
        @(negedge clk);
        check("w1_drop_valid", 64'(out_valid), 64'd0);

        // Stuffed 0xFF 0x00
        send(8'h11); send(8'hFF); send(8'h00); send(8'h22);
        send(8'h33); send(8'h44); send(8'h55); send(8'h66);
        check("w2_early_valid", 64'(out_valid), 64'd0);
        send(8'h77);
        check_word("w2", 64'h11FF223344556677, 4'd8);
        @(negedge clk);

        // Backpressure
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(8'hA0 + 8'(i));
        check_word("w3", 64'hA0A1A2A3A4A5A6A7, 4'd8);
        held = out_data;
        u_if.data  = 8'hB0;
        u_if.valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            check("w3_stall_ready", 64'(u_if.ready), 64'd0);
            check("w3_stable", out_data, held);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1 check("w3_release_ready", 64'(u_if.ready), 64'd1);
        @(negedge clk);
        u_if.valid = 1'b0;
        check("w3_accepted", 64'(out_valid), 64'd0);
        for (int i = 1; i < 8; i++) send(8'hB0 + 8'(i));
        check_word("w4", 64'hB0B1B2B3B4B5B6B7, 4'd8);
        @(negedge clk);

`ifdef U2D_MARKER_EN
        send(8'hAA); send(8'hBB); send(8'hFF); send(8'hD9);
        check_word("mk1", 64'hAABBFFFFFFFFFFFF, 4'd2);
        check("mk1_last", 64'(out_last), 64'd1);
        check("mk1_marker", 64'(out_marker), 64'hD9);
        @(negedge clk);
        send(8'hFF); send(8'hD9);
        check_word("mk2", 64'hFFFFFFFFFFFFFFFF, 4'd0);
        check("mk2_last", 64'(out_last), 64'd1);
        @(negedge clk);
        for (int i = 0; i < 8; i++) send(8'hC0 + 8'(i));
        check_word("mk3", 64'hC0C1C2C3C4C5C6C7, 4'd8);
        check("mk3_last", 64'(out_last), 64'd0);
        @(negedge clk);
`else
        send(8'hFF); send(8'hD9);
        for (int i = 1; i <= 6; i++) send(8'(i));
        check("ff_early_valid", 64'(out_valid), 64'd0);
        send(8'h07);
        check_word("ff", 64'hFF01020304050607, 4'd8);
        @(negedge clk);
`endif

        // Reset mid-word with a pending 0xFF
        for (int i = 0; i < 5; i++) send(8'h50 + 8'(i));
        send(8'hFF);
        rst_n = 1'b0;
        #1;
        check("mrst_valid", 64'(out_valid), 64'd0);
        check("mrst_data", out_data, 64'd0);
        check("mrst_nbytes", 64'(out_nbytes), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 7; i++) send(8'h21 + 8'(i));
        check("mrst_early_valid", 64'(out_valid), 64'd0);
        send(8'h28);
        check_word("mrst", 64'h2122232425262728, 4'd8);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
